// File: rtl/opcodes.sv
// Shared types for the ALU arbiter slice: instruction/register words,
// RV32 R-type masks, and the arbiter FSM state encoding.
package opcodes;

   typedef logic [31:0] instruction_t;
   typedef logic [31:0] register_t;

   localparam instruction_t R_MASK    = 32'hFE00_707F;
   localparam instruction_t ADD_MATCH = 32'h0000_0033;
   localparam instruction_t SUB_MATCH = 32'h4000_0033;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: search starts one past last_grant and wraps.
// Ports: req (requests), last_grant (index), grant (one-hot), grant_idx, any.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IW   = (NREQ > 2) ? 2 : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last_grant,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx,
   output logic            any
);

   logic [IW-1:0] k;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      k         = '0;
      for (int i = 1; i <= NREQ; i++) begin
         k = IW'((int'(last_grant) + i) % NREQ);
         if (!any && req[k]) begin
            any       = 1'b1;
            grant[k]  = 1'b1;
            grant_idx = k;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU among NREQ requesters: grant, issue, return.
// Ports: req_* (requests in), resp_* (results out), alu_* (ALU side), op_count.
module alu_arbiter
   import opcodes::*;
#(
   parameter int NREQ = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  instruction_t [NREQ-1:0]  req_instr,
   input  register_t [NREQ-1:0]     req_op1,
   input  register_t [NREQ-1:0]     req_op2,
   input  register_t [NREQ-1:0]     req_pc,
   output logic [NREQ-1:0]          resp_valid,
   input  logic [NREQ-1:0]          resp_ready,
   output register_t                resp_result,
   output instruction_t             alu_instr,
   output register_t                alu_op1,
   output register_t                alu_op2,
   output register_t                alu_pc,
   output logic                     alu_enable,
   input  register_t                alu_result,
   output logic [31:0]              op_count
);

   localparam int IW = (NREQ > 2) ? 2 : 1;

   arb_state_t    state, state_n;
   logic [NREQ-1:0] grant;
   logic [IW-1:0] grant_idx, gnt_q, last_q;
   logic          any, done, fresh_q;
   instruction_t  instr_q;
   register_t     op1_q, op2_q, pc_q, result_q;
   logic [31:0]   cnt_q;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
      .req        (req_valid),
      .last_grant (last_q),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .any        (any)
   );

   assign done = (state == RESP) && resp_ready[gnt_q];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (any) state_n = EXEC;
         EXEC:    state_n = RESP;
         RESP:    if (done) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // The ALU result is only on alu_result during the first RESP cycle,
   // so that cycle forwards it and later cycles show the held copy.
   always_comb begin
      req_ready   = '0;
      resp_valid  = '0;
      alu_enable  = 1'b0;
      resp_result = result_q;
      unique case (state)
         IDLE: if (rst) req_ready = grant;
         EXEC: alu_enable = 1'b1;
         RESP: begin
            resp_valid[gnt_q] = 1'b1;
            if (fresh_q) resp_result = alu_result;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr_q  <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         pc_q     <= '0;
         gnt_q    <= '0;
         last_q   <= IW'(NREQ - 1);
         result_q <= '0;
         fresh_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         fresh_q <= (state == EXEC);
         if (state == IDLE && any) begin
            instr_q <= req_instr[grant_idx];
            op1_q   <= req_op1[grant_idx];
            op2_q   <= req_op2[grant_idx];
            pc_q    <= req_pc[grant_idx];
            gnt_q   <= grant_idx;
         end
         if (fresh_q) result_q <= alu_result;
         if (done) begin
            cnt_q  <= cnt_q + 32'd1;
            last_q <= gnt_q;
         end
      end
   end

   assign alu_instr = instr_q;
   assign alu_op1   = op1_q;
   assign alu_op2   = op2_q;
   assign alu_pc    = pc_q;
   assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU.
// Ports: none; drives the arbiter and models the ALU beside it.
module tb_alu_arbiter;
   import opcodes::*;

   logic               clk = 1'b0;
   logic               rst;
   logic [1:0]         req_valid, req_ready, resp_valid, resp_ready;
   instruction_t [1:0] req_instr;
   register_t [1:0]    req_op1, req_op2, req_pc;
   register_t          resp_result, alu_op1, alu_op2, alu_pc;
   register_t          alu_result = '0;
   instruction_t       alu_instr;
   logic               alu_enable;
   logic [31:0]        op_count;
   int                 total = 0;
   int                 bad   = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.NREQ(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_instr(req_instr), .req_op1(req_op1),
      .req_op2(req_op2), .req_pc(req_pc),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result),
      .alu_instr(alu_instr), .alu_op1(alu_op1),
      .alu_op2(alu_op2), .alu_pc(alu_pc),
      .alu_enable(alu_enable), .alu_result(alu_result),
      .op_count(op_count)
   );

   always @(posedge clk)
      if (alu_enable)
         alu_result <= ((alu_instr & R_MASK) == SUB_MATCH) ?
                       alu_op1 - alu_op2 : alu_op1 + alu_op2;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic one_op(input int r, input instruction_t ins,
                         input register_t a, input register_t b,
                         input register_t pc, input register_t exp);
      @(negedge clk);
      req_valid = 2'(1 << r);
      req_instr[r] = ins;
      req_op1[r] = a;
      req_op2[r] = b;
      req_pc[r] = pc;
      #1 chk("grant", 32'(req_ready), 32'(1 << r));
      @(negedge clk);
      req_valid = '0;
      #1 chk("alu_en", 32'(alu_enable), 32'd1);
      chk("alu_op1", alu_op1, a);
      chk("alu_op2", alu_op2, b);
      chk("alu_pc", alu_pc, pc);
      @(negedge clk);
      resp_ready = 2'(1 << r);
      #1 chk("resp_valid", 32'(resp_valid), 32'(1 << r));
      chk("result", resp_result, exp);
      @(negedge clk);
      resp_ready = '0;
      #1 chk("resp_done", 32'(resp_valid), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running want done");
      $fatal(1);
   end

   initial begin
      int          g_exp [4] = '{0, 1, 0, 1};
      logic [31:0] r_exp [4] = '{101, 202, 102, 203};
      logic        seen;
      rst = 1'b0;
      req_valid = '0;
      resp_ready = '0;
      req_instr = '0;
      req_op1 = '0;
      req_op2 = '0;
      req_pc = '0;
      #12;
      chk("rst_rdy", 32'(req_ready), 0);
      chk("rst_rv", 32'(resp_valid), 0);
      chk("rst_en", 32'(alu_enable), 0);
      chk("rst_res", resp_result, 0);
      chk("rst_op1", alu_op1, 0);
      chk("rst_cnt", op_count, 0);
      @(negedge clk);
      rst = 1'b1;

      one_op(0, ADD_MATCH, 5, 7, 32'h100, 12);
      chk("cnt1", op_count, 1);

      do_reset();
      @(negedge clk);
      req_valid = 2'b11;
      resp_ready = 2'b11;
      req_instr[0] = ADD_MATCH;
      req_instr[1] = ADD_MATCH;
      req_op1[0] = 100;
      req_op2[0] = 1;
      req_op1[1] = 200;
      req_op2[1] = 2;
      for (int k = 0; k < 4; k++) begin
         #1 chk("rr_grant", 32'(req_ready), 32'(1 << g_exp[k]));
         @(negedge clk);
         req_op1[g_exp[k]] = req_op1[g_exp[k]] + 1;
         #1 chk("rr_en", 32'(alu_enable), 1);
         @(negedge clk);
         #1 chk("rr_rv", 32'(resp_valid), 32'(1 << g_exp[k]));
         chk("rr_res", resp_result, r_exp[k]);
         @(negedge clk);
      end
      req_valid = '0;
      resp_ready = '0;
      #1 chk("rr_cnt", op_count, 4);

      @(negedge clk);
      req_valid = 2'b10;
      req_instr[1] = SUB_MATCH;
      req_op1[1] = 0;
      req_op2[1] = 1;
      #1 chk("sub_grant", 32'(req_ready), 32'b10);
      @(negedge clk);
      req_valid = 2'b01;
      req_instr[0] = ADD_MATCH;
      req_op1[0] = 3;
      req_op2[0] = 4;
      resp_ready = 2'b01;
      #1 chk("exec_busy", 32'(req_ready), 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 4) resp_ready = 2'b10;
         #1 chk("hold_rv", 32'(resp_valid), 32'b10);
         chk("hold_res", resp_result, 32'hFFFF_FFFF);
         chk("hold_rdy", 32'(req_ready), 0);
         chk("hold_cnt", op_count, 4);
      end
      @(negedge clk);
      resp_ready = '0;
      #1 chk("sub_cnt", op_count, 5);
      chk("next_grant", 32'(req_ready), 32'b01);

      @(negedge clk);
      #1 chk("pre_rst_en", 32'(alu_enable), 1);
      rst = 1'b0;
      #1 chk("ar_en", 32'(alu_enable), 0);
      chk("ar_op1", alu_op1, 0);
      chk("ar_res", resp_result, 0);
      chk("ar_cnt", op_count, 0);
      chk("ar_rdy", 32'(req_ready), 0);
      chk("ar_rv", 32'(resp_valid), 0);
      @(negedge clk);
      rst = 1'b1;
      req_valid = '0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         #1 seen = seen | (|resp_valid);
      end
      chk("no_stale", 32'(seen), 0);
      one_op(1, ADD_MATCH, 8, 9, 32'h200, 17);
      chk("post_cnt", op_count, 1);

      @(negedge clk);
      dut.cnt_q = 32'hFFFF_FFFF;
      one_op(0, ADD_MATCH, 1, 1, 32'h300, 2);
      chk("wrap_cnt", op_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters sharing one alu instance (range 2..4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  NREQ  requester i presents an operation.
REQ-005 SHALL have port req_ready  output  NREQ  one-hot; operation i accepted this cycle.
REQ-006 SHALL have port req_instr  input  NREQ x instruction_t  per-requester instruction.
REQ-007 SHALL have port req_op1 / req_op2 / req_pc  input  NREQ x register_t each  per-requester operands and PC.
REQ-008 SHALL have port resp_valid  output  NREQ  one-hot; result for requester i held on resp_result.
REQ-009 SHALL have port resp_ready  input  NREQ  requester i consumes result.
REQ-010 SHALL have port resp_result  output  register_t  shared result bus.
REQ-011 SHALL have port alu_instr / alu_op1 / alu_op2 / alu_pc  output  instruction_t / register_t  operands to alu.
REQ-012 SHALL have port alu_enable  output  1  one-cycle alu enable strobe.
REQ-013 SHALL have port alu_result  input  register_t  registered alu output, valid the cycle after alu_enable.
REQ-014 SHALL have port op_count  output  32  count of completed handshakes since reset.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 IDLE: if any req_valid, SHALL grant one requester by round-robin, pulse req_ready[g] for that cycle, latch instr/op1/op2/pc and g, go to EXEC; else stay.
REQ-017 Round-robin: search SHALL start at index (last_grant+1) mod NREQ; last_grant resets to NREQ-1, so requester 0 wins first.
REQ-018 EXEC: SHALL drive latched operands on alu_* and alu_enable=1 for exactly one cycle, then go to RESP.
REQ-019 alu_* data outputs SHALL hold the latched values in all states; alu_enable SHALL be 0 outside EXEC.
REQ-020 RESP entry: SHALL capture alu_result into the result register; resp_valid[g]=1 from that cycle.
REQ-021 RESP: resp_result and resp_valid SHALL stay stable until resp_ready[g]=1; on that cycle go to IDLE, increment op_count, update last_grant=g.
REQ-022 resp_ready of non-granted requesters SHALL be ignored.
REQ-023 Grant-to-result latency SHALL be 2 cycles (req_ready cycle to first resp_valid cycle); minimum issue interval 3 cycles.
REQ-024 No grant SHALL be issued while in EXEC or RESP; req_ready SHALL be 0 there.
REQ-025 A requester dropping req_valid before grant SHALL lose nothing; dropping after grant SHALL not cancel the operation.
REQ-026 op_count SHALL wrap from FFFFFFFF to 0.
REQ-027 Result arithmetic is the alu's; arbiter SHALL pass 32-bit values unmodified.

Reset
REQ-028 On rst low, asynchronously: state=IDLE, req_ready=0, resp_valid=0, alu_enable=0, resp_result=0, alu_* data=0, op_count=0, last_grant=NREQ-1.
REQ-029 Reset in EXEC or RESP SHALL discard the in-flight operation; no resp_valid after release.
REQ-030 First grant SHALL be possible on the first posedge after rst deasserts.

Structure
REQ-031 instruction_t, register_t and instruction masks SHALL come from package opcodes; the arbiter state enum SHALL be added to opcodes.
REQ-032 Round-robin grant logic SHALL be a sub-module rr_arbiter (NREQ requests in, one-hot grant out, last-grant input).
REQ-033 alu SHALL remain outside this block; its enable is driven solely by alu_enable.

Verification
REQ-034 req_valid[0], ADD op1=5 op2=7 -> req_ready[0] cycle N, alu_enable cycle N+1, resp_valid[0] with resp_result=12 cycle N+2, op_count=1 after handshake.
REQ-035 req_valid=2'b11 held, resp_ready=2'b11 -> grants alternate 0,1,0,1; four results returned in that order.
REQ-036 SUB op1=0 op2=1 on requester 1, resp_ready[1] low 4 cycles -> resp_result=FFFFFFFF stable 5 cycles, req_ready stays 0 despite req_valid[0].
REQ-037 rst low during EXEC -> all outputs 0 immediately; after release no resp_valid for the dropped op; next request returns normally.
REQ-038 resp_ready[0] high while resp_valid[1] -> no completion; state stays RESP until resp_ready[1].
REQ-039 op_count forced near wrap (FFFFFFFF) via 1 completion -> reads 0.
